// File: rtl/control_pipe_pkg.sv
// LC-3b control types shared by decode and the control pipeline.
// Optional two-phase LDI/STI support is enabled by CTRL_INDIRECT_EN.
package control_pipe_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  localparam lc3b_opcode OP_BR   = 4'h0;
  localparam lc3b_opcode OP_ADD  = 4'h1;
  localparam lc3b_opcode OP_LDB  = 4'h2;
  localparam lc3b_opcode OP_STB  = 4'h3;
  localparam lc3b_opcode OP_JSR  = 4'h4;
  localparam lc3b_opcode OP_AND  = 4'h5;
  localparam lc3b_opcode OP_LDR  = 4'h6;
  localparam lc3b_opcode OP_STR  = 4'h7;
  localparam lc3b_opcode OP_RTI  = 4'h8;
  localparam lc3b_opcode OP_NOT  = 4'h9;
  localparam lc3b_opcode OP_LDI  = 4'hA;
  localparam lc3b_opcode OP_STI  = 4'hB;
  localparam lc3b_opcode OP_JMP  = 4'hC;
  localparam lc3b_opcode OP_SHF  = 4'hD;
  localparam lc3b_opcode OP_LEA  = 4'hE;
  localparam lc3b_opcode OP_TRAP = 4'hF;

  typedef enum logic [3:0] {
    alu_add, alu_and, alu_not, alu_pass,
    alu_sll, alu_srl, alu_sra
  } lc3b_aluop;

  typedef enum logic {IDLE, IND2} lc3b_ctrl_state;

  typedef logic [1:0] lc3b_wb_sel;
  localparam lc3b_wb_sel WB_PC   = 2'd0;
  localparam lc3b_wb_sel WB_MEM  = 2'd1;
  localparam lc3b_wb_sel WB_ADDR = 2'd2;
  localparam lc3b_wb_sel WB_ALU  = 2'd3;

  typedef struct packed {
    lc3b_aluop  aluop;
    logic       load_cc;
    logic       load_regfile;
    logic       load_pc;
    logic       read_memory;
    logic       write_memory;
    logic [1:0] pc_mux_sel;
    lc3b_wb_sel wb_mux_sel;
    logic [1:0] offset_mux_sel;
    logic       address_mux_sel;
    logic       immsr2_mux_sel;
    logic       instrsr1_mux_sel;
    logic       dest_mux_sel;
  } lc3b_control;

  localparam lc3b_control CTRL_BUBBLE = '{
    aluop:            alu_pass,
    load_cc:          1'b0,
    load_regfile:     1'b0,
    load_pc:          1'b0,
    read_memory:      1'b0,
    write_memory:     1'b0,
    pc_mux_sel:       2'd0,
    wb_mux_sel:       WB_PC,
    offset_mux_sel:   2'd0,
    address_mux_sel:  1'b1,
    immsr2_mux_sel:   1'b1,
    instrsr1_mux_sel: 1'b0,
    dest_mux_sel:     1'b0
  };

  function automatic logic indirect(lc3b_word i);
    return (i[15:12] == OP_LDI) || (i[15:12] == OP_STI);
  endfunction

endpackage

// File: rtl/control_pipe_decode.sv
// Combinational LC-3b decode: (instr, phase) -> control word.
// LDI/STI phases are decoded only when CTRL_INDIRECT_EN is defined.
module control_decode
  import control_pipe_pkg::*;
(
  input  lc3b_word    instr_i,
  input  logic        phase_i,
  output lc3b_control ctrl_o
);

  lc3b_opcode op;
  assign op = instr_i[15:12];

  logic unused_bits;
  assign unused_bits = ^{instr_i[10:6], instr_i[3:0]};

`ifndef CTRL_INDIRECT_EN
  logic unused_phase;
  assign unused_phase = phase_i;
`endif

  // Opcode to control-word mapping
  always_comb begin
    ctrl_o = CTRL_BUBBLE;
    unique case (1'b1)
      op == OP_ADD, op == OP_AND, op == OP_NOT: begin
        ctrl_o.aluop = (op == OP_ADD) ? alu_add :
                       (op == OP_AND) ? alu_and : alu_not;
        ctrl_o.immsr2_mux_sel = instr_i[5];
        ctrl_o.wb_mux_sel     = WB_ALU;
        ctrl_o.load_regfile   = 1'b1;
        ctrl_o.load_cc        = 1'b1;
      end
      op == OP_SHF: begin
        unique case (instr_i[5:4])
          2'b00:   ctrl_o.aluop = alu_sll;
          2'b11:   ctrl_o.aluop = alu_sra;
          default: ctrl_o.aluop = alu_srl;
        endcase
        ctrl_o.wb_mux_sel   = WB_ALU;
        ctrl_o.load_regfile = 1'b1;
        ctrl_o.load_cc      = 1'b1;
      end
      op == OP_LDR, op == OP_LDB: begin
        ctrl_o.read_memory      = 1'b1;
        ctrl_o.wb_mux_sel       = WB_MEM;
        ctrl_o.offset_mux_sel   = 2'd1;
        ctrl_o.instrsr1_mux_sel = 1'b1;
        ctrl_o.load_regfile     = 1'b1;
        ctrl_o.load_cc          = 1'b1;
      end
      op == OP_STR, op == OP_STB: begin
        ctrl_o.write_memory   = 1'b1;
        ctrl_o.offset_mux_sel = 2'd1;
      end
      op == OP_LEA: begin
        ctrl_o.wb_mux_sel     = WB_ADDR;
        ctrl_o.offset_mux_sel = 2'd2;
        ctrl_o.load_regfile   = 1'b1;
        ctrl_o.load_cc        = 1'b1;
      end
      op == OP_BR: begin
        ctrl_o.offset_mux_sel = 2'd2;
      end
      op == OP_JMP: begin
        ctrl_o.load_pc    = 1'b1;
        ctrl_o.pc_mux_sel = 2'd1;
      end
      op == OP_JSR: begin
        ctrl_o.load_pc      = 1'b1;
        ctrl_o.pc_mux_sel   = instr_i[11] ? 2'd2 : 2'd1;
        ctrl_o.dest_mux_sel = 1'b1;
        ctrl_o.wb_mux_sel   = WB_PC;
        ctrl_o.load_regfile = 1'b1;
      end
      op == OP_TRAP: begin
        ctrl_o.read_memory  = 1'b1;
        ctrl_o.load_pc      = 1'b1;
        ctrl_o.pc_mux_sel   = 2'd3;
        ctrl_o.dest_mux_sel = 1'b1;
        ctrl_o.wb_mux_sel   = WB_PC;
        ctrl_o.load_regfile = 1'b1;
      end
`ifdef CTRL_INDIRECT_EN
      op == OP_LDI, op == OP_STI: begin
        if (!phase_i) begin
          ctrl_o.read_memory    = 1'b1;
          ctrl_o.offset_mux_sel = 2'd1;
        end else if (op == OP_LDI) begin
          ctrl_o.read_memory     = 1'b1;
          ctrl_o.address_mux_sel = 1'b0;
          ctrl_o.wb_mux_sel      = WB_MEM;
          ctrl_o.load_regfile    = 1'b1;
          ctrl_o.load_cc         = 1'b1;
        end else begin
          ctrl_o.write_memory    = 1'b1;
          ctrl_o.address_mux_sel = 1'b0;
        end
      end
`endif
      default: ctrl_o = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Control-word pipeline with stall, young-stage flush and LDI/STI FSM.
// Define CTRL_INDIRECT_EN to build the two-phase indirect sequencer.
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          instr_valid,
  input  lc3b_word                      instr,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          instr_take,
  output lc3b_control [NUM_STAGES-1:0]  ctrl_out,
  output logic [NUM_STAGES-1:0]         stage_valid
);

  lc3b_control [NUM_STAGES-1:0] ctrl_q, ctrl_d;
  logic [NUM_STAGES-1:0]        valid_q, valid_d;
  lc3b_control                  dec;
  logic                         ind2;
  logic                         adv_ok;

  assign adv_ok = instr_valid & ~stall & ~flush & ~reset;

`ifdef CTRL_INDIRECT_EN
  lc3b_ctrl_state state_q;

  assign ind2       = (state_q == IND2);
  assign instr_take = adv_ok & (ind2 | ~indirect(instr));

  // Indirect sequencer: phase 1 then phase 2, aborted by flush
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (flush) begin
      state_q <= IDLE;
    end else if (!stall && instr_valid) begin
      unique case (state_q)
        IDLE:    state_q <= indirect(instr) ? IND2 : IDLE;
        IND2:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign ind2       = 1'b0;
  assign instr_take = adv_ok;
`endif

  control_decode u_decode (
    .instr_i (instr),
    .phase_i (ind2),
    .ctrl_o  (dec)
  );

  // Next stage contents: shift on advance, then squash young stages
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (!stall) begin
      ctrl_d  = {ctrl_q[NUM_STAGES-2:0],
                 instr_valid ? dec : CTRL_BUBBLE};
      valid_d = {valid_q[NUM_STAGES-2:0], instr_valid};
    end
    if (flush) begin
      for (int i = 0; i < FLUSH_STAGES; i++) begin
        ctrl_d[i]  = CTRL_BUBBLE;
        valid_d[i] = 1'b0;
      end
    end
  end

  // Per-stage control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= {NUM_STAGES{CTRL_BUBBLE}};
      valid_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl_out    = ctrl_q;
  assign stage_valid = valid_q;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe against a spec-level model.
// Indirect checks follow CTRL_INDIRECT_EN when it is defined.
module tb_control_pipe;
  import control_pipe_pkg::*;

  localparam int NS = 4;
  localparam int FS = 2;

  logic clk = 1'b0;
  logic reset, instr_valid, stall, flush, instr_take;
  lc3b_word instr;
  lc3b_control [NS-1:0] ctrl_out;
  logic [NS-1:0] stage_valid;

  control_pipe #(.NUM_STAGES(NS), .FLUSH_STAGES(FS)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid),
    .instr(instr), .stall(stall), .flush(flush),
    .instr_take(instr_take), .ctrl_out(ctrl_out),
    .stage_valid(stage_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  lc3b_control   m_ctrl [NS];
  logic [NS-1:0] m_valid;
  bit            m_ind2;

  function automatic lc3b_control bub();
    lc3b_control c;
    c = '0;
    c.aluop = alu_pass;
    c.address_mux_sel = 1'b1;
    c.immsr2_mux_sel = 1'b1;
    return c;
  endfunction

  function automatic bit is_ind(lc3b_word w);
`ifdef CTRL_INDIRECT_EN
    return (w[15:12] == OP_LDI) || (w[15:12] == OP_STI);
`else
    return 1'b0;
`endif
  endfunction

  function automatic lc3b_control exp_ctrl(lc3b_word w, bit ph2);
    lc3b_control c;
    lc3b_opcode op;
    bit p1, ldi2, sti2;
    op = w[15:12];
    p1 = is_ind(w) && !ph2;
    ldi2 = is_ind(w) && ph2 && op == OP_LDI;
    sti2 = is_ind(w) && ph2 && op == OP_STI;
    c = bub();
    if (op == OP_ADD) c.aluop = alu_add;
    if (op == OP_AND) c.aluop = alu_and;
    if (op == OP_NOT) c.aluop = alu_not;
    if (op == OP_SHF)
      c.aluop = (w[5:4] == 2'b00) ? alu_sll :
                (w[5:4] == 2'b11) ? alu_sra : alu_srl;
    c.load_regfile = (op inside {OP_ADD, OP_AND, OP_NOT, OP_SHF,
      OP_LDR, OP_LDB, OP_LEA, OP_JSR, OP_TRAP}) || ldi2;
    c.load_cc = (op inside {OP_ADD, OP_AND, OP_NOT, OP_SHF,
      OP_LDR, OP_LDB, OP_LEA}) || ldi2;
    c.load_pc = op inside {OP_JMP, OP_JSR, OP_TRAP};
    c.read_memory = (op inside {OP_LDR, OP_LDB, OP_TRAP})
      || p1 || ldi2;
    c.write_memory = (op inside {OP_STR, OP_STB}) || sti2;
    c.pc_mux_sel = (op == OP_JMP) ? 2'd1 :
                   (op == OP_JSR) ? (w[11] ? 2'd2 : 2'd1) :
                   (op == OP_TRAP) ? 2'd3 : 2'd0;
    c.wb_mux_sel = (op inside {OP_ADD, OP_AND, OP_NOT, OP_SHF}) ? 2'd3 :
                   ((op inside {OP_LDR, OP_LDB}) || ldi2) ? 2'd1 :
                   (op == OP_LEA) ? 2'd2 : 2'd0;
    c.offset_mux_sel =
      ((op inside {OP_LDR, OP_LDB, OP_STR, OP_STB}) || p1) ? 2'd1 :
      (op inside {OP_LEA, OP_BR}) ? 2'd2 : 2'd0;
    c.address_mux_sel = !(ldi2 || sti2);
    c.immsr2_mux_sel = (op inside {OP_ADD, OP_AND, OP_NOT}) ? w[5] : 1'b1;
    c.instrsr1_mux_sel = op inside {OP_LDR, OP_LDB};
    c.dest_mux_sel = op inside {OP_JSR, OP_TRAP};
    return c;
  endfunction

  function automatic bit exp_take();
    return instr_valid && !stall && !flush && !reset &&
           (m_ind2 || !is_ind(instr));
  endfunction

  function automatic lc3b_word rnd_plain();
    lc3b_word w;
    w = lc3b_word'($urandom);
    if (w[15:12] == OP_LDI || w[15:12] == OP_STI) w[15:12] = OP_ADD;
    return w;
  endfunction

  task automatic drive(input logic r, input logic v, input lc3b_word w,
                       input logic s, input logic f);
    reset = r; instr_valid = v; instr = w; stall = s; flush = f;
    #1;
  endtask

  task automatic tick();
    lc3b_control oc [NS];
    logic [NS-1:0] ov;
    @(posedge clk);
    oc = m_ctrl;
    ov = m_valid;
    if (reset) begin
      for (int i = 0; i < NS; i++) m_ctrl[i] = bub();
      m_valid = '0;
      m_ind2 = 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (flush && i < FS) begin
          m_ctrl[i] = bub(); m_valid[i] = 1'b0;
        end else if (stall) begin
          m_ctrl[i] = oc[i]; m_valid[i] = ov[i];
        end else if (i == 0) begin
          m_ctrl[0] = instr_valid ? exp_ctrl(instr, m_ind2) : bub();
          m_valid[0] = instr_valid;
        end else begin
          m_ctrl[i] = oc[i-1]; m_valid[i] = ov[i-1];
        end
      end
      if (flush) m_ind2 = 1'b0;
      else if (!stall && instr_valid)
        m_ind2 = m_ind2 ? 1'b0 : is_ind(instr);
    end
    #1;
  endtask

  task automatic fill4();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, rnd_plain(), 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1, 1, 16'h12A3, 0, 0);
    n_cmp++;
    if (instr_take !== 1'b0) begin
      n_bad++; $display("FAIL reset_take: got %b want 0", instr_take);
    end
    tick();
    n_cmp++;
    if (stage_valid !== 4'b0000) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0000", stage_valid);
    end
    for (int i = 0; i < NS; i++) begin
      n_cmp++;
      if (ctrl_out[i] !== bub()) begin
        n_bad++;
        $display("FAIL reset_ctrl%0d: got %h want %h", i, ctrl_out[i], bub());
      end
    end
  endtask

  task automatic test_add();
    logic [NS-1:0] ev;
    drive(0, 1, 16'h12A3, 0, 0);
    n_cmp++;
    if (instr_take !== 1'b1) begin
      n_bad++; $display("FAIL add_take: got %b want 1", instr_take);
    end
    tick();
    drive(0, 0, 16'h0000, 0, 0);
    n_cmp++;
    if (ctrl_out[0].aluop !== alu_add || ctrl_out[0].immsr2_mux_sel !== 1'b1
        || ctrl_out[0].wb_mux_sel !== 2'd3 || !ctrl_out[0].load_regfile) begin
      n_bad++; $display("FAIL add_ctrl0: got %h want aluop add imm 1 wb 3",
                        ctrl_out[0]);
    end
    ev = 4'b0001;
    for (int k = 0; k < NS; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if (stage_valid !== ev) begin
        n_bad++; $display("FAIL add_valid%0d: got %b want %b", k, stage_valid, ev);
      end
      n_cmp++;
      if (ctrl_out[k] !== exp_ctrl(16'h12A3, 0)) begin
        n_bad++; $display("FAIL add_stage%0d: got %h want %h", k,
                          ctrl_out[k], exp_ctrl(16'h12A3, 0));
      end
      ev = ev << 1;
    end
  endtask

  task automatic test_indirect();
    lc3b_word w;
    for (int j = 0; j < 2; j++) begin
      w = (j == 0) ? 16'hA5BF : 16'hB5BF;
      drive(0, 1, w, 0, 0);
`ifdef CTRL_INDIRECT_EN
      n_cmp++;
      if (instr_take !== 1'b0) begin
        n_bad++; $display("FAIL ind_take1_%0d: got %b want 0", j, instr_take);
      end
      tick();
      n_cmp++;
      if (!ctrl_out[0].read_memory || ctrl_out[0].load_regfile
          || ctrl_out[0].write_memory || !stage_valid[0]) begin
        n_bad++; $display("FAIL ind_ph1_%0d: got %h want read only", j, ctrl_out[0]);
      end
      n_cmp++;
      if (instr_take !== 1'b1) begin
        n_bad++; $display("FAIL ind_take2_%0d: got %b want 1", j, instr_take);
      end
      tick();
      n_cmp++;
      if (ctrl_out[0].address_mux_sel !== 1'b0 ||
          ctrl_out[0].load_regfile !== (j == 0) ||
          ctrl_out[0].write_memory !== (j == 1)) begin
        n_bad++; $display("FAIL ind_ph2_%0d: got %h want phase 2", j, ctrl_out[0]);
      end
      n_cmp++;
      if (ctrl_out[1] !== exp_ctrl(w, 0) || stage_valid[1:0] !== 2'b11) begin
        n_bad++; $display("FAIL ind_order_%0d: got %h want %h", j,
                          ctrl_out[1], exp_ctrl(w, 0));
      end
`else
      n_cmp++;
      if (instr_take !== 1'b1) begin
        n_bad++; $display("FAIL ind_take_%0d: got %b want 1", j, instr_take);
      end
      tick();
      n_cmp++;
      if (ctrl_out[0] !== bub() || stage_valid[0] !== 1'b1) begin
        n_bad++; $display("FAIL ind_bubble_%0d: got %h want %h", j,
                          ctrl_out[0], bub());
      end
`endif
    end
    drive(0, 0, 16'h0000, 0, 0);
  endtask

  task automatic test_stall();
    fill4();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, rnd_plain(), 1, 0);
      n_cmp++;
      if (instr_take !== 1'b0) begin
        n_bad++; $display("FAIL stall_take%0d: got %b want 0", k, instr_take);
      end
      tick();
      n_cmp++;
      if (stage_valid !== 4'b1111) begin
        n_bad++; $display("FAIL stall_valid%0d: got %b want 1111", k, stage_valid);
      end
      for (int i = 0; i < NS; i++) begin
        n_cmp++;
        if (ctrl_out[i] !== m_ctrl[i]) begin
          n_bad++; $display("FAIL stall_ctrl%0d: got %h want %h", i,
                            ctrl_out[i], m_ctrl[i]);
        end
      end
    end
  endtask

  task automatic test_flush(input logic s);
    lc3b_control old2;
    fill4();
    old2 = s ? m_ctrl[2] : m_ctrl[1];
    drive(0, 1, rnd_plain(), s, 1);
    n_cmp++;
    if (instr_take !== 1'b0) begin
      n_bad++; $display("FAIL flush_take_s%0d: got %b want 0", s, instr_take);
    end
    tick();
    n_cmp++;
    if (stage_valid !== 4'b1100) begin
      n_bad++; $display("FAIL flush_valid_s%0d: got %b want 1100", s, stage_valid);
    end
    n_cmp++;
    if (ctrl_out[0] !== bub() || ctrl_out[1] !== bub()) begin
      n_bad++; $display("FAIL flush_young_s%0d: got %h want %h", s,
                        ctrl_out[1], bub());
    end
    n_cmp++;
    if (ctrl_out[2] !== old2 || ctrl_out[3] !== m_ctrl[3]) begin
      n_bad++; $display("FAIL flush_old_s%0d: got %h want %h", s,
                        ctrl_out[2], old2);
    end
  endtask

  task automatic test_ind_abort(input logic use_reset);
`ifdef CTRL_INDIRECT_EN
    drive(0, 1, 16'hA5BF, 0, 0);
    tick();
    drive(use_reset, 1, 16'hA5BF, 0, !use_reset);
    n_cmp++;
    if (instr_take !== 1'b0) begin
      n_bad++; $display("FAIL abort_take_r%0d: got %b want 0", use_reset, instr_take);
    end
    tick();
    n_cmp++;
    if (stage_valid[0] !== 1'b0 || (use_reset && stage_valid !== 4'b0000)) begin
      n_bad++; $display("FAIL abort_valid_r%0d: got %b", use_reset, stage_valid);
    end
    drive(0, 1, 16'hA5BF, 0, 0);
    n_cmp++;
    if (instr_take !== 1'b0) begin
      n_bad++; $display("FAIL abort_restart_r%0d: got %b want 0", use_reset, instr_take);
    end
    tick();
    n_cmp++;
    if (ctrl_out[0] !== exp_ctrl(16'hA5BF, 0)) begin
      n_bad++; $display("FAIL abort_ph1_r%0d: got %h want %h", use_reset,
                        ctrl_out[0], exp_ctrl(16'hA5BF, 0));
    end
    tick();
    drive(0, 0, 16'h0000, 0, 0);
`else
    drive(use_reset, 0, 16'h0000, 0, 0);
    tick();
    drive(0, 0, 16'h0000, 0, 0);
`endif
  endtask

  task automatic test_random();
    lc3b_word w;
    logic r, v, s, f;
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 99) < 20);
      f = ($urandom_range(0, 99) < 10);
      v = m_ind2 ? 1'b1 : ($urandom_range(0, 99) < 75);
      w = lc3b_word'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:12] = {3'b101, w[12]};
      if (m_ind2) w = instr;
      drive(r, v, w, s, f);
      n_cmp++;
      if (instr_take !== exp_take()) begin
        n_bad++; $display("FAIL rnd_take@%0d: got %b want %b", k,
                          instr_take, exp_take());
      end
      tick();
      n_cmp++;
      if (stage_valid !== m_valid) begin
        n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", k,
                          stage_valid, m_valid);
      end
      for (int i = 0; i < NS; i++) begin
        n_cmp++;
        if (ctrl_out[i] !== m_ctrl[i]) begin
          n_bad++; $display("FAIL rnd_ctrl%0d@%0d: got %h want %h", i, k,
                            ctrl_out[i], m_ctrl[i]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NS; i++) m_ctrl[i] = bub();
    m_valid = '0;
    m_ind2 = 1'b0;
    test_reset();
    test_add();
    test_indirect();
    test_stall();
    test_flush(1'b0);
    test_flush(1'b1);
    test_ind_abort(1'b1);
    test_ind_abort(1'b0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
